// File: rtl/mem_ctrl.sv
// ============================================================================
// mem_ctrl
// ----------------------------------------------------------------------------
// This is the memory-side responder for the instruction cache (port 0) and
// the data cache (port 1). It arbitrates one request at a time between the
// two ports, models main memory with a fixed access latency, and returns one
// full cache line for every request.
//
// Each request follows this sequence:
//   - IDLE : the winning request is captured and grant_o pulses.
//   - BUSY : the latency counter runs from 1 up to MEM_LATENCY.
//   - RESP : resp_o pulses and fill_o carries the line. For a store, fill_o
//            carries the line after the write.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   req_i        in   [2]        request per port (0 = icache, 1 = dcache)
//   instr_i      in   [2]        per port: 0 = store, 1 = load
//   line_addr_i  in   [2][LINE_ADDR_BITS]  per-port line address
//   word_idx_i   in   [2][2]     per-port word within the line (stores only)
//   wdata_i      in   [2][WORD_LEN]  per-port store word
//   grant_o      out  [2]        one-cycle pulse: request captured
//   resp_o       out  [2]        one-cycle pulse: access complete
//   fill_o       out  LINE_LEN   returned line; held until the next response
//
// Optional feature (macro MEM_CTRL_PERF_EN):
//   load_cnt_o   out  [32]       count of completed loads; wraps to 0
//   store_cnt_o  out  [32]       count of completed stores; wraps to 0
//
// The memory array is not reset. Line addresses that are equal modulo
// MEM_LINES select the same line, because the upper bits are ignored.
// ============================================================================
module mem_ctrl #(
    parameter int LINE_LEN       = 128,
    parameter int WORD_LEN       = 32,
    parameter int LINE_ADDR_BITS = 28,
    parameter int MEM_LINES      = 4096,
    parameter int MEM_LATENCY    = 5
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [1:0]                          req_i,
    input  logic [1:0]                          instr_i,
    input  logic [1:0][LINE_ADDR_BITS-1:0]      line_addr_i,
    input  logic [1:0][1:0]                     word_idx_i,
    input  logic [1:0][WORD_LEN-1:0]            wdata_i,
    output logic [1:0]                          grant_o,
    output logic [1:0]                          resp_o,
    output logic [LINE_LEN-1:0]                 fill_o
`ifdef MEM_CTRL_PERF_EN
    ,
    output logic [31:0]                         load_cnt_o,
    output logic [31:0]                         store_cnt_o
`endif
);

    localparam int IDX_BITS = $clog2(MEM_LINES);
    localparam logic [7:0] LAT_LAST = 8'(MEM_LATENCY);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]                state;
    logic [7:0]                lat_cnt;
    logic                      rr_ptr;
    logic                      win;

    // These registers hold the captured request. They stay stable from the
    // grant until the response, so the requester may drop its inputs after
    // it sees grant_o.
    logic                      cur_port;
    logic                      cur_instr;
    logic [LINE_ADDR_BITS-1:0] cur_addr;
    logic [1:0]                cur_widx;
    logic [WORD_LEN-1:0]       cur_wdata;

    logic [LINE_LEN-1:0]       mem [MEM_LINES];
    logic [IDX_BITS-1:0]       mem_idx;
    logic [LINE_LEN-1:0]       mem_line;
    logic [LINE_LEN-1:0]       merged_line;
    logic                      commit;

    // When both ports request, the port named by the round-robin pointer
    // wins. A single requester always wins. When no port requests, win is
    // not used.
    always_comb begin
        win = rr_ptr;
        if (req_i == 2'b01) begin
            win = 1'b0;
        end else if (req_i == 2'b10) begin
            win = 1'b1;
        end
    end

    // The upper line-address bits are dropped here. This truncation is what
    // makes aliased addresses select the same line.
    always_comb begin
        mem_idx     = IDX_BITS'(cur_addr);
        mem_line    = mem[mem_idx];
        merged_line = mem_line;
        merged_line[int'(cur_widx)*WORD_LEN +: WORD_LEN] = cur_wdata;
    end

    // commit is high in the last BUSY cycle. At that edge the response
    // registers load, and a store updates the array.
    assign commit = (state == ST_BUSY) && (lat_cnt == LAT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            lat_cnt   <= 8'd0;
            rr_ptr    <= 1'b0;
            grant_o   <= 2'b00;
            resp_o    <= 2'b00;
            fill_o    <= '0;
            cur_port  <= 1'b0;
            cur_instr <= 1'b0;
            cur_addr  <= '0;
            cur_widx  <= 2'b00;
            cur_wdata <= '0;
        end else begin
            grant_o <= 2'b00;
            resp_o  <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (|req_i) begin
                        cur_port  <= win;
                        cur_instr <= instr_i[win];
                        cur_addr  <= line_addr_i[win];
                        cur_widx  <= word_idx_i[win];
                        cur_wdata <= wdata_i[win];
                        grant_o   <= win ? 2'b10 : 2'b01;
                        rr_ptr    <= ~win;
                        lat_cnt   <= 8'd1;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (commit) begin
                        resp_o <= cur_port ? 2'b10 : 2'b01;
                        fill_o <= cur_instr ? mem_line : merged_line;
                        state  <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The array is written only at the commit edge. A reset that arrives
    // earlier therefore drops an in-flight store without touching memory.
    always_ff @(posedge clk) begin
        if (!reset && commit && !cur_instr) begin
            mem[mem_idx] <= merged_line;
        end
    end

`ifdef MEM_CTRL_PERF_EN
    // Both counters step on the commit edge of their access type. They wrap
    // naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_cnt_o  <= 32'd0;
            store_cnt_o <= 32'd0;
        end else if (commit) begin
            if (cur_instr) begin
                load_cnt_o <= load_cnt_o + 32'd1;
            end else begin
                store_cnt_o <= store_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// tb_mem_ctrl
// ----------------------------------------------------------------------------
// Directed bench for mem_ctrl with the default parameters (MEM_LATENCY = 5,
// MEM_LINES = 4096). Inputs change on the falling edge and outputs are
// sampled on the falling edge, half a cycle away from the active edge.
// ============================================================================
module tb_mem_ctrl;

    logic              clk;
    logic              reset;
    logic [1:0]        req_i;
    logic [1:0]        instr_i;
    logic [1:0][27:0]  line_addr_i;
    logic [1:0][1:0]   word_idx_i;
    logic [1:0][31:0]  wdata_i;
    logic [1:0]        grant_o;
    logic [1:0]        resp_o;
    logic [127:0]      fill_o;
`ifdef MEM_CTRL_PERF_EN
    logic [31:0]       load_cnt_o;
    logic [31:0]       store_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] LINE10 =
        {32'hA000_0003, 32'hDEAD_BEEF, 32'hA000_0001, 32'hA000_0000};

    mem_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .instr_i     (instr_i),
        .line_addr_i (line_addr_i),
        .word_idx_i  (word_idx_i),
        .wdata_i     (wdata_i),
        .grant_o     (grant_o),
        .resp_o      (resp_o),
        .fill_o      (fill_o)
`ifdef MEM_CTRL_PERF_EN
        ,
        .load_cnt_o  (load_cnt_o),
        .store_cnt_o (store_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_i = 2'b00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one complete transaction on a single port. It waits, with a
    // bound, for the grant and then for the response.
    task automatic applyStimulus(input int port, input logic instr,
                                 input logic [27:0] addr, input logic [1:0] widx,
                                 input logic [31:0] wd, output logic [127:0] line);
        logic [1:0] onehot;
        int n;
        onehot = (port == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        req_i[port]       = 1'b1;
        instr_i[port]     = instr;
        line_addr_i[port] = addr;
        word_idx_i[port]  = widx;
        wdata_i[port]     = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_o == 2'b00 && n < 30);
        checkOutput("txn_grant", 128'(grant_o), 128'(onehot));
        req_i[port] = 1'b0;
        n = 0;
        while (resp_o == 2'b00 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("txn_resp", 128'(resp_o), 128'(onehot));
        line = fill_o;
        @(negedge clk);
    endtask

    // Port 0 loads line 0x10. Port 1 also requests line 0x10, either from
    // the start (p1_at_start) or from the grant cycle onward, which is
    // during BUSY. Port 1 must then be granted exactly one idle cycle after
    // resp_o[0].
    task automatic overlap_test(input string tag, input logic p1_at_start);
        logic [1:0] quiet;
        @(negedge clk);
        req_i          = {p1_at_start, 1'b1};
        instr_i        = 2'b11;
        line_addr_i[0] = 28'h10;
        line_addr_i[1] = 28'h10;
        @(negedge clk);
        checkOutput({tag, "_grant0"}, 128'(grant_o), 128'(2'b01));
        req_i = 2'b10;
        quiet = 2'b00;
        repeat (4) begin
            @(negedge clk);
            quiet |= grant_o | resp_o;
        end
        checkOutput({tag, "_busy0_quiet"}, 128'(quiet), 128'(0));
        @(negedge clk);
        checkOutput({tag, "_resp0"}, 128'(resp_o), 128'(2'b01));
        checkOutput({tag, "_fill0"}, fill_o, LINE10);
        @(negedge clk);
        checkOutput({tag, "_idle_nogrant"}, 128'(grant_o), 128'(0));
        @(negedge clk);
        checkOutput({tag, "_grant1"}, 128'(grant_o), 128'(2'b10));
        req_i = 2'b00;
        quiet = 2'b00;
        repeat (4) begin
            @(negedge clk);
            quiet |= grant_o | resp_o;
        end
        checkOutput({tag, "_busy1_quiet"}, 128'(quiet), 128'(0));
        @(negedge clk);
        checkOutput({tag, "_resp1"}, 128'(resp_o), 128'(2'b10));
        checkOutput({tag, "_fill1"}, fill_o, LINE10);
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] line;
        logic [1:0]   quiet;
        int           n;

        reset       = 1'b1;
        req_i       = 2'b00;
        instr_i     = 2'b00;
        line_addr_i = '0;
        word_idx_i  = '0;
        wdata_i     = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_grant", 128'(grant_o), 128'(0));
        checkOutput("rst_resp", 128'(resp_o), 128'(0));
        checkOutput("rst_fill", fill_o, 128'(0));
        reset = 1'b0;

        // A port 0 load should give the grant one cycle later and the
        // response MEM_LATENCY cycles after that.
        @(negedge clk);
        req_i = 2'b01; instr_i[0] = 1'b1; line_addr_i[0] = 28'h20;
        @(negedge clk);
        checkOutput("lat_grant", 128'(grant_o), 128'(2'b01));
        checkOutput("lat_noresp", 128'(resp_o), 128'(0));
        req_i = 2'b00;
        quiet = 2'b00;
        repeat (4) begin
            @(negedge clk);
            quiet |= grant_o | resp_o;
        end
        checkOutput("lat_quiet", 128'(quiet), 128'(0));
        @(negedge clk);
        checkOutput("lat_resp", 128'(resp_o), 128'(2'b01));
        checkOutput("lat_grant_off", 128'(grant_o), 128'(0));
        @(negedge clk);
        checkOutput("lat_resp_pulse", 128'(resp_o), 128'(0));

        // Fill line 0x10 with known words, overwrite word 2, then read it back.
        for (int w = 0; w < 4; w++) begin
            applyStimulus(1, 1'b0, 28'h10, 2'(w), 32'hA000_0000 + 32'(w), line);
        end
        checkOutput("st_prefill",
                    line, {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
        applyStimulus(1, 1'b0, 28'h10, 2'd2, 32'hDEAD_BEEF, line);
        checkOutput("st_merged", line, LINE10);
        applyStimulus(1, 1'b1, 28'h10, 2'd0, 32'h0, line);
        checkOutput("ld_word2", 128'(line[95:64]), 128'(32'hDEAD_BEEF));
        checkOutput("ld_line", line, LINE10);

        // Both ports request right after reset, so port 0 goes first. In the
        // second run, port 1 raises its request while port 0 is in BUSY.
        do_reset();
        overlap_test("simul", 1'b1);
        overlap_test("busyreq", 1'b0);

        // A grant for port 0 alone moves the pointer to port 1, so the next
        // simultaneous pair grants port 1 first.
        applyStimulus(0, 1'b1, 28'h10, 2'd0, 32'h0, line);
        @(negedge clk);
        req_i = 2'b11; instr_i = 2'b11;
        line_addr_i[0] = 28'h10; line_addr_i[1] = 28'h10;
        @(negedge clk);
        checkOutput("ptr_grant1_first", 128'(grant_o), 128'(2'b10));
        req_i = 2'b01;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_o == 2'b00 && n < 30);
        checkOutput("ptr_grant0_second", 128'(grant_o), 128'(2'b01));
        req_i = 2'b00;
        n = 0;
        while (resp_o == 2'b00 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ptr_resp0", 128'(resp_o), 128'(2'b01));
        @(negedge clk);

        // A reset that lands in BUSY aborts the store. The old word
        // survives, and the pointer returns to port 0.
        applyStimulus(0, 1'b0, 28'h3, 2'd0, 32'h1111_1111, line);
        @(negedge clk);
        req_i[1] = 1'b1; instr_i[1] = 1'b0; line_addr_i[1] = 28'h3;
        word_idx_i[1] = 2'd0; wdata_i[1] = 32'h1234_5678;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_o == 2'b00 && n < 30);
        checkOutput("abort_grant", 128'(grant_o), 128'(2'b10));
        req_i = 2'b00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        quiet = 2'b00;
        repeat (8) begin
            @(negedge clk);
            quiet |= resp_o;
        end
        checkOutput("abort_noresp", 128'(quiet), 128'(0));
        req_i = 2'b11; instr_i = 2'b11;
        line_addr_i[0] = 28'h3; line_addr_i[1] = 28'h3;
        @(negedge clk);
        checkOutput("abort_ptr_reset", 128'(grant_o), 128'(2'b01));
        req_i = 2'b10;
        n = 0;
        while (resp_o == 2'b00 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_resp0", 128'(resp_o), 128'(2'b01));
        checkOutput("abort_old_word", 128'(fill_o[31:0]), 128'(32'h1111_1111));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_o == 2'b00 && n < 30);
        checkOutput("abort_grant1", 128'(grant_o), 128'(2'b10));
        req_i = 2'b00;
        n = 0;
        while (resp_o == 2'b00 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_resp1", 128'(resp_o), 128'(2'b10));
        @(negedge clk);

        // Line 0x1005 and line 0x0005 alias, because only the low 12 bits
        // index the array.
        do_reset();
        @(negedge clk);
        checkOutput("alias_rst_fill", fill_o, 128'(0));
        applyStimulus(0, 1'b0, 28'h1005, 2'd1, 32'hCAFE_F00D, line);
        applyStimulus(1, 1'b1, 28'h0005, 2'd0, 32'h0, line);
        checkOutput("alias_word1", 128'(line[63:32]), 128'(32'hCAFE_F00D));
        @(negedge clk);
        checkOutput("fill_hold", 128'(fill_o[63:32]), 128'(32'hCAFE_F00D));
`ifdef MEM_CTRL_PERF_EN
        checkOutput("perf_store_cnt", 128'(store_cnt_o), 128'(1));
        checkOutput("perf_load_cnt", 128'(load_cnt_o), 128'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
